// File: rtl/serial_mag_cmp_if.sv
// Bundle of request/result signals for the serial magnitude comparator.
// start is a request that is accepted only while the block is idle. A start
// seen during busy or done is dropped, never queued. done is a one-cycle pulse,
// and eq/gt/lt/slices stay valid from that pulse until the next accepted start.
interface serial_mag_cmp_if #(
  parameter int WIDTH = 8
);
  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = $clog2(NSLICE) + 1;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [CW-1:0]    slices;

  modport master (
    output start, a, b,
    input  busy, done, eq, gt, lt, slices
  );

  modport slave (
    input  start, a, b,
    output busy, done, eq, gt, lt, slices
  );
endinterface

// File: rtl/serial_mag_cmp_ctrl.sv
// Unsigned magnitude comparator that scans captured operands MSB-first,
// one 2-bit slice per cycle, and stops at the first unequal slice.
module serial_mag_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_mag_cmp_if.slave    bus,
  output logic [1:0]         state_dbg
);
  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = $clog2(NSLICE) + 1;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             eq_r;
  logic             gt_r;
  logic             lt_r;
  logic [CW-1:0]    slices_r;
  logic [1:0]       sa;
  logic [1:0]       sb;
  logic             last;

  // The single shared slice datapath: pick slice idx from each operand.
  always_comb begin
    sa   = 2'(a_r >> {idx, 1'b0});
    sb   = 2'(b_r >> {idx, 1'b0});
    last = (idx == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = SCAN;
      SCAN: if ((sa != sb) || last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      idx      <= '0;
      cnt      <= '0;
      eq_r     <= 1'b0;
      gt_r     <= 1'b0;
      lt_r     <= 1'b0;
      slices_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            idx      <= IW'(NSLICE - 1);
            cnt      <= '0;
            eq_r     <= 1'b0;
            gt_r     <= 1'b0;
            lt_r     <= 1'b0;
            slices_r <= '0;
          end
        end
        SCAN: begin
          if (sa > sb) begin
            gt_r     <= 1'b1;
            slices_r <= cnt + CW'(1);
          end else if (sa < sb) begin
            lt_r     <= 1'b1;
            slices_r <= cnt + CW'(1);
          end else if (last) begin
            // Terminal case wins over the decrement so idx never wraps.
            eq_r     <= 1'b1;
            slices_r <= CW'(NSLICE);
          end else begin
            idx <= idx - IW'(1);
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == SCAN);
  assign bus.done   = (state == DONE);
  assign bus.eq     = eq_r;
  assign bus.gt     = gt_r;
  assign bus.lt     = lt_r;
  assign bus.slices = slices_r;
  assign state_dbg  = state;
endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Directed-vector bench for serial_mag_cmp_ctrl at WIDTH=8.
module tb_serial_mag_cmp_ctrl;
  localparam int WIDTH = 8;
  localparam int CW    = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         vectors;
  int         miscompares;

  serial_mag_cmp_if #(.WIDTH(WIDTH)) bus ();

  serial_mag_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one compare and stop in the done cycle; k = slices expected.
  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic eeq, input logic egt, input logic elt,
                         input int k);
    int cyc;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      step();
      cyc++;
    end
    check({tag, "_done"},    32'(bus.done),   32'd1);
    check({tag, "_latency"}, 32'(cyc),        32'(k + 1));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_eq"},      32'(bus.eq),     32'(eeq));
    check({tag, "_gt"},      32'(bus.gt),     32'(egt));
    check({tag, "_lt"},      32'(bus.lt),     32'(elt));
    check({tag, "_slices"},  32'(bus.slices), 32'(k));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    #12;
    check("rst_state",  32'(state_dbg),  32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_res",    32'({bus.eq, bus.gt, bus.lt}), 32'd0);
    check("rst_slices", 32'(bus.slices), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // MSB slice differs: shortest scan
    run_cmp("c3_43", 8'hC3, 8'h43, 1'b0, 1'b1, 1'b0, 1);
    step();
    check("c3_43_idle", 32'(state_dbg), 32'd0);

    // Equal operands: full scan
    run_cmp("5a_5a", 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 4);
    step();

    // Only slice 0 differs
    run_cmp("12_13", 8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 4);
    step();
    run_cmp("ff_00", 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1);

    // start during DONE is dropped; previous result held
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h13;
    step();
    check("ign_state",  32'(state_dbg),  32'd0);
    check("ign_busy",   32'(bus.busy),   32'd0);
    check("ign_gt",     32'(bus.gt),     32'd1);
    check("ign_lt",     32'(bus.lt),     32'd0);
    check("ign_slices", 32'(bus.slices), 32'd1);
    bus.start = 1'b0;
    step();
    check("ign_state2", 32'(state_dbg),  32'd0);
    check("hold_gt",    32'(bus.gt),     32'd1);

    // start held high, a changed after capture
    bus.a     = 8'h20;
    bus.b     = 8'h10;
    bus.start = 1'b1;
    step();
    check("hold_c1_busy", 32'(bus.busy), 32'd1);
    bus.a = 8'h00;
    step();
    check("hold_c2_busy", 32'(bus.busy), 32'd1);
    check("hold_c2_done", 32'(bus.done), 32'd0);
    step();
    check("hold_c3_done",   32'(bus.done),   32'd1);
    check("hold_c3_gt",     32'(bus.gt),     32'd1);
    check("hold_c3_slices", 32'(bus.slices), 32'd2);
    step();
    check("hold_c4_done",  32'(bus.done), 32'd0);
    check("hold_c4_state", 32'(state_dbg), 32'd0);
    step();
    check("hold_c5_busy", 32'(bus.busy), 32'd1);
    check("hold_c5_clr",  32'({bus.eq, bus.gt, bus.lt}), 32'd0);
    bus.start = 1'b0;
    step();
    check("hold_c6_done", 32'(bus.done), 32'd0);
    step();
    check("hold_c7_done",   32'(bus.done),   32'd1);
    check("hold_c7_lt",     32'(bus.lt),     32'd1);
    check("hold_c7_gt",     32'(bus.gt),     32'd0);
    check("hold_c7_slices", 32'(bus.slices), 32'd2);
    step();

    // Reset in the middle of a scan
    bus.a     = 8'h55;
    bus.b     = 8'h55;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check("abort_c2_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_state",  32'(state_dbg),  32'd0);
    check("abort_busy",   32'(bus.busy),   32'd0);
    check("abort_done",   32'(bus.done),   32'd0);
    check("abort_res",    32'({bus.eq, bus.gt, bus.lt}), 32'd0);
    check("abort_slices", 32'(bus.slices), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_cmp("01_02", 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 4);
    step();
    check("end_state", 32'(state_dbg), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
